cnf_sequencer: RTL and testbench

Upstream control stage for the serial CNF evaluator. It holds a formula as a packed literal list in a small internal memory. On `start` it walks the list and drives the evaluator's literal and strobe inputs (`varPos`, `negCtrl`, `enableClause`, `resetClause`, `enableCNF`, `resetCNF`). It then samples the evaluator's `outCNF` and reports a one-cycle `done` plus a held `sat` verdict.

---
 rtl/cnf_sequencer.sv | 160 ++++++++++++++++
 tb/tb_cnf_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnf_sequencer.sv
// cnf_sequencer: walks a packed literal list held in a small local memory and
// drives the serial CNF evaluator's literal and strobe inputs. After the last
// clause it samples the evaluator result and reports done/sat/err.
// Literal entry layout: [4:0] variable, [5] negate, [6] end-of-clause,
// [7] end-of-formula (an end-of-formula entry also closes its clause).
module cnf_sequencer #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic [7:0]    wrData,
  input  logic          start,
  input  logic          outCNF,
  output logic [4:0]    varPos,
  output logic          negCtrl,
  output logic          enableClause,
  output logic          resetClause,
  output logic          enableCNF,
  output logic          resetCNF,
  output logic          busy,
  output logic          done,
  output logic          sat,
  output logic          err
);

  localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};

  typedef enum logic [2:0] {
    sIdle,
    sInit,
    sLit,
    sCnfEn,
    sClsRst,
    sWait,
    sDone
  } state_t;

  state_t        state;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptrInc;
  logic [7:0]    mem [2**AW];
  logic [7:0]    curEntry;
  logic [5:0]    nextLit;
  logic          curEoc;
  logic          curEof;
  logic          atEnd;

  // The entry under the pointer steers the walk; the following entry is
  // fetched so the next literal can be loaded straight into the output flops.
  assign ptrInc   = ptr + AW'(1);
  assign curEntry = mem[ptr];
  assign nextLit  = mem[ptrInc][5:0];
  assign curEof   = curEntry[7];
  assign curEoc   = curEntry[6] | curEntry[7];
  assign atEnd    = (ptr == PTR_MAX);

  // Literal memory: host writes only while idle; contents survive reset.
  always_ff @(posedge clk) begin
    if (wrEn && !busy) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Sequencer FSM; every evaluator-facing output is a flop loaded with the
  // value belonging to the state being entered, so the active-low resets
  // never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= sIdle;
      ptr          <= '0;
      varPos       <= '0;
      negCtrl      <= 1'b0;
      enableClause <= 1'b0;
      resetClause  <= 1'b0;
      enableCNF    <= 1'b0;
      resetCNF     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sat          <= 1'b0;
      err          <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // DONE behaves like IDLE so a start seen during done runs back-to-back.
        sIdle, sDone: begin
          resetClause  <= 1'b1;
          resetCNF     <= 1'b1;
          enableClause <= 1'b0;
          enableCNF    <= 1'b0;
          state        <= sIdle;
          if (start) begin
            state       <= sInit;
            ptr         <= '0;
            resetClause <= 1'b0;
            resetCNF    <= 1'b0;
            busy        <= 1'b1;
            sat         <= 1'b0;
            err         <= 1'b0;
          end
        end
        sInit: begin
          state        <= sLit;
          varPos       <= curEntry[4:0];
          negCtrl      <= curEntry[5];
          enableClause <= 1'b1;
          resetClause  <= 1'b1;
          resetCNF     <= 1'b1;
        end
        sLit: begin
          if (curEoc || atEnd) begin
            // The last memory slot closes the clause (and the formula) even
            // without the marker bits; the pointer never wraps.
            state        <= sCnfEn;
            enableClause <= 1'b0;
            enableCNF    <= 1'b1;
            if (!curEoc) begin
              err <= 1'b1;
            end
          end else begin
            ptr     <= ptrInc;
            varPos  <= nextLit[4:0];
            negCtrl <= nextLit[5];
          end
        end
        sCnfEn: begin
          enableCNF <= 1'b0;
          if (curEof || atEnd) begin
            state <= sWait;
            if (!curEof) begin
              err <= 1'b1;
            end
          end else begin
            ptr         <= ptrInc;
            state       <= sClsRst;
            resetClause <= 1'b0;
          end
        end
        sClsRst: begin
          state        <= sLit;
          resetClause  <= 1'b1;
          enableClause <= 1'b1;
          varPos       <= curEntry[4:0];
          negCtrl      <= curEntry[5];
        end
        sWait: begin
          sat   <= outCNF;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= sDone;
        end
        default: begin
          state <= sIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnf_sequencer.sv
// Bench for cnf_sequencer: a behavioural serial CNF evaluator closes the loop,
// expected verdicts and latencies are queued when a run is launched and
// compared when done appears.
module tb_cnf_sequencer;

  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          wrEn;
  logic [AW-1:0] wrAddr;
  logic [7:0]    wrData;
  logic          start;
  logic          outCNF;
  logic [4:0]    varPos;
  logic          negCtrl, enableClause, resetClause, enableCNF, resetCNF;
  logic          busy, done, sat, err;

  logic          sWrEn, sStart, sOut;
  logic [1:0]    sWrAddr;
  logic [7:0]    sWrData;
  logic [4:0]    sVarPos;
  logic          sNegCtrl, sEnableClause, sResetClause, sEnableCNF, sResetCNF;
  logic          sBusy, sDone, sSat, sErr;

  logic [31:0]   truthVal;
  logic          clauseAcc, cnfAcc;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct {
    logic sat;
    logic err;
    int   lat;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  cnf_sequencer #(.AW(AW)) dut (
    .clk(clk), .reset(reset), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .start(start), .outCNF(outCNF), .varPos(varPos), .negCtrl(negCtrl),
    .enableClause(enableClause), .resetClause(resetClause),
    .enableCNF(enableCNF), .resetCNF(resetCNF), .busy(busy), .done(done),
    .sat(sat), .err(err)
  );

  cnf_sequencer #(.AW(2)) dutSmall (
    .clk(clk), .reset(reset), .wrEn(sWrEn), .wrAddr(sWrAddr), .wrData(sWrData),
    .start(sStart), .outCNF(sOut), .varPos(sVarPos), .negCtrl(sNegCtrl),
    .enableClause(sEnableClause), .resetClause(sResetClause),
    .enableCNF(sEnableCNF), .resetCNF(sResetCNF), .busy(sBusy), .done(sDone),
    .sat(sSat), .err(sErr)
  );

  // Serial evaluator: clause OR-accumulator and formula AND-accumulator.
  always_ff @(posedge clk or negedge resetClause) begin
    if (!resetClause) clauseAcc <= 1'b0;
    else if (enableClause) clauseAcc <= clauseAcc | (truthVal[varPos] ^ negCtrl);
  end

  always_ff @(posedge clk or negedge resetCNF) begin
    if (!resetCNF) cnfAcc <= 1'b1;
    else if (enableCNF) cnfAcc <= cnfAcc & clauseAcc;
  end

  assign outCNF = cnfAcc;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic evalCnf(input logic [7:0] ent[$], input logic [31:0] tv);
    logic res;
    logic cls;
    res = 1'b1;
    cls = 1'b0;
    foreach (ent[i]) begin
      cls = cls | (tv[ent[i][4:0]] ^ ent[i][5]);
      if (ent[i][6] | ent[i][7]) begin
        res = res & cls;
        cls = 1'b0;
      end
      if (ent[i][7]) break;
    end
    return res;
  endfunction

  // done lands N + 2C + 2 cycles after the start edge.
  function automatic int expLatency(input logic [7:0] ent[$]);
    int n;
    int c;
    n = 0;
    c = 0;
    foreach (ent[i]) begin
      n++;
      if (ent[i][6] | ent[i][7]) c++;
      if (ent[i][7]) break;
    end
    return n + 2 * c + 2;
  endfunction

  task automatic loadFormula(input logic [7:0] ent[$]);
    foreach (ent[i]) begin
      wrEn   = 1'b1;
      wrAddr = AW'(i);
      wrData = ent[i];
      @(posedge clk); #1;
    end
    wrEn = 1'b0;
  endtask

  task automatic pushExp(input logic [7:0] ent[$], input logic [31:0] tv);
    exp_t e;
    e.sat = evalCnf(ent, tv);
    e.err = 1'b0;
    e.lat = expLatency(ent);
    sb.push_back(e);
  endtask

  // Leaves the caller #1 into cycle 1 after the start edge.
  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int firstCyc);
    int   cyc;
    exp_t e;
    cyc = firstCyc;
    while (!done && cyc < 200) begin
      checkVal({tag, " busy"}, busy, 1);
      @(posedge clk); #1;
      cyc++;
    end
    if (sb.size() == 0) begin
      checkVal({tag, " scoreboard empty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    if (!done) begin
      checkVal({tag, " done timeout"}, 0, 1);
    end else begin
      checkVal({tag, " latency"}, cyc, e.lat);
      checkVal({tag, " sat"}, sat, e.sat);
      checkVal({tag, " err"}, err, e.err);
      checkVal({tag, " busy at done"}, busy, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1[$];
    logic [7:0] f2[$];
    logic [7:0] f3[$];
    logic [4:0] trFlags [1:9];
    logic [5:0] trLit [1:9];
    exp_t       e;
    int         cyc;

    f1 = '{8'h00, 8'h41, 8'h21, 8'hC2};
    f2 = '{8'h41, 8'hC0};
    f3 = '{8'hE3};
    // {enableClause, enableCNF, resetClause, resetCNF, busy} per cycle of f1
    trFlags = '{5'b00001, 5'b10111, 5'b10111, 5'b01111, 5'b00011,
                5'b10111, 5'b10111, 5'b01111, 5'b00111};
    trLit   = '{6'h00, 6'h00, 6'h01, 6'h00, 6'h00, 6'h21, 6'h02, 6'h00, 6'h00};

    reset = 1'b1; wrEn = 1'b0; wrAddr = '0; wrData = '0; start = 1'b0;
    sWrEn = 1'b0; sWrAddr = '0; sWrData = '0; sStart = 1'b0; sOut = 1'b0;
    truthVal = 32'h5;
    repeat (3) @(posedge clk);
    #1;
    checkVal("reset outputs", {resetClause, resetCNF, enableClause, enableCNF,
                               busy, done, sat, err, negCtrl}, 9'b0);
    checkVal("reset varPos", varPos, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("idle resets released", {resetClause, resetCNF, busy}, 3'b110);

    // Test 1: (x0 | x1)(~x1 | x2), strobes traced cycle by cycle.
    loadFormula(f1);
    pushExp(f1, truthVal);
    launch();
    for (int c = 1; c <= 9; c++) begin
      checkVal($sformatf("t1 c%0d strobes", c),
               {enableClause, enableCNF, resetClause, resetCNF, busy}, trFlags[c]);
      if (trFlags[c][4]) checkVal($sformatf("t1 c%0d literal", c), {negCtrl, varPos}, trLit[c]);
      checkVal($sformatf("t1 c%0d done", c), done, 0);
      @(posedge clk); #1;
    end
    waitDone("t1", 10);
    @(posedge clk); #1;
    checkVal("t1 done one cycle", done, 0);
    checkVal("t1 sat held", sat, 1);

    // Test 2: (x1)(x0), then an immediate back-to-back rerun from the done cycle.
    loadFormula(f2);
    pushExp(f2, truthVal);
    launch();
    waitDone("t2", 1);
    pushExp(f2, truthVal);
    launch();
    waitDone("t2 back-to-back", 1);

    // Test 3: single literal ~x3; formula reset only in cycle 1.
    @(posedge clk); #1;
    loadFormula(f3);
    pushExp(f3, truthVal);
    launch();
    checkVal("t3 c1 resetCNF", resetCNF, 0);
    for (int c = 2; c <= 4; c++) begin
      @(posedge clk); #1;
      checkVal($sformatf("t3 c%0d resetCNF", c), resetCNF, 1);
    end
    @(posedge clk); #1;
    waitDone("t3", 5);

    // Test 5: start and wrEn pulsed while busy are ignored.
    @(posedge clk); #1;
    loadFormula(f1);
    pushExp(f1, truthVal);
    launch();
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; wrEn = 1'b1; wrAddr = '0; wrData = 8'hFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0; wrEn = 1'b0;
    waitDone("t5 disturbed", 5);
    @(posedge clk); #1;
    pushExp(f1, truthVal);
    launch();
    waitDone("t5 rerun", 1);

    // Test 6: asynchronous reset in a LIT cycle aborts the run.
    @(posedge clk); #1;
    launch();
    @(posedge clk); #1;
    checkVal("t6 in LIT", enableClause, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    checkVal("t6 reset outputs", {resetClause, resetCNF, busy, done, err}, 5'b0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checkVal("t6 no done in reset", done, 0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checkVal("t6 no done after reset", done, 0);
    pushExp(f1, truthVal);
    launch();
    waitDone("t6 fresh run", 1);
    @(posedge clk); #1;
    checkVal("t6 sat before reset", sat, 1);
    reset = 1'b1;
    #2;
    checkVal("t6 reset clears sat", sat, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Test 4: AW=2 instance, four entries without markers -> overrun.
    for (int i = 0; i < 4; i++) begin
      sWrEn = 1'b1; sWrAddr = 2'(i); sWrData = 8'(i);
      @(posedge clk); #1;
    end
    sWrEn = 1'b0;
    e.sat = 1'b0; e.err = 1'b1; e.lat = 8;
    sb.push_back(e);
    sStart = 1'b1;
    @(posedge clk); #1;
    sStart = 1'b0;
    cyc = 1;
    while (!sDone && cyc < 50) begin
      if (cyc == 1) checkVal("ovf c1 resets", {sResetClause, sResetCNF}, 2'b00);
      if (cyc >= 2 && cyc <= 5) begin
        checkVal($sformatf("ovf c%0d enableClause", cyc), sEnableClause, 1);
        checkVal($sformatf("ovf c%0d literal", cyc), {sNegCtrl, sVarPos}, cyc - 2);
      end
      if (cyc == 6) checkVal("ovf c6 cnf strobe", {sEnableCNF, sEnableClause}, 2'b10);
      checkVal($sformatf("ovf c%0d busy", cyc), sBusy, 1);
      @(posedge clk); #1;
      cyc++;
    end
    e = sb.pop_front();
    checkVal("ovf latency", cyc, e.lat);
    checkVal("ovf err", sErr, e.err);
    checkVal("ovf sat", sSat, e.sat);
    checkVal("ovf done", sDone, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
